// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with a word-serial line refill port.
// Hit/miss performance counters are built only when ICACHE_PERF_EN is defined.
module icache #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        rob_clear,
  output logic        hit,
  output logic [31:0] hit_inst,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses
);
  localparam int unsigned LINES     = 2 ** INDEX_BITS;
  localparam int unsigned WORDS     = 2 ** OFFSET_BITS;
  localparam int unsigned BASE_BITS = 32 - OFFSET_BITS - 2;
  localparam int unsigned TAG_BITS  = BASE_BITS - INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd1,
    S_MISS = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LINES-1:0]       r_valid;
  logic [TAG_BITS-1:0]    r_tag  [LINES];
  logic [31:0]            r_data [LINES][WORDS];
  logic [BASE_BITS-1:0]   r_line_hi;
  logic [OFFSET_BITS-1:0] r_cnt;

  logic [BASE_BITS-1:0]   w_pc_hi;
  logic [OFFSET_BITS-1:0] w_pc_off;
  logic [INDEX_BITS-1:0]  w_pc_idx;
  logic [TAG_BITS-1:0]    w_pc_tag;
  logic [INDEX_BITS-1:0]  w_fill_idx;
  logic [TAG_BITS-1:0]    w_fill_tag;
  logic [OFFSET_BITS-1:0] w_cnt_inc;
  logic                   w_lookup;
  logic                   w_tag_hit;
  logic                   w_last;

  logic                   w_hit_nxt;
  logic [31:0]            w_hit_inst_nxt;
  logic                   w_req_valid_nxt;
  logic [31:0]            w_req_addr_nxt;
  logic [BASE_BITS-1:0]   w_line_hi_nxt;
  logic [OFFSET_BITS-1:0] w_cnt_nxt;
  logic                   w_fill_we;
  logic                   w_install;
  logic                   w_count_hit;
  logic                   w_count_miss;
  logic                   w_unused_pc;

  assign w_pc_hi     = fetch_pc[31:OFFSET_BITS+2];
  assign w_pc_off    = fetch_pc[OFFSET_BITS+1:2];
  assign w_pc_idx    = w_pc_hi[INDEX_BITS-1:0];
  assign w_pc_tag    = w_pc_hi[BASE_BITS-1:INDEX_BITS];
  assign w_fill_idx  = r_line_hi[INDEX_BITS-1:0];
  assign w_fill_tag  = r_line_hi[BASE_BITS-1:INDEX_BITS];
  assign w_cnt_inc   = r_cnt + OFFSET_BITS'(1);
  assign w_last      = (r_cnt == OFFSET_BITS'(WORDS - 1));
  assign w_lookup    = fetch_valid && !rob_clear;
  assign w_tag_hit   = r_valid[w_pc_idx] && (r_tag[w_pc_idx] == w_pc_tag);
  assign w_unused_pc = ^fetch_pc[1:0];

  // State register; rdy_in low freezes the FSM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_lookup) begin
          w_state_nxt = w_tag_hit ? S_RESP : S_MISS;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      S_MISS: begin
        if (mem_resp_valid && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath decode; RESP swallows the fetch unit's late-dropped fetch_valid.
  always_comb begin
    w_hit_nxt       = 1'b0;
    w_hit_inst_nxt  = hit_inst;
    w_req_valid_nxt = mem_req_valid;
    w_req_addr_nxt  = mem_req_addr;
    w_line_hi_nxt   = r_line_hi;
    w_cnt_nxt       = r_cnt;
    w_fill_we       = 1'b0;
    w_install       = 1'b0;
    w_count_hit     = 1'b0;
    w_count_miss    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_lookup) begin
          if (w_tag_hit) begin
            w_hit_nxt      = 1'b1;
            w_hit_inst_nxt = r_data[w_pc_idx][w_pc_off];
            w_count_hit    = 1'b1;
          end else begin
            w_line_hi_nxt   = w_pc_hi;
            w_cnt_nxt       = '0;
            w_req_valid_nxt = 1'b1;
            w_req_addr_nxt  = {w_pc_hi, {OFFSET_BITS{1'b0}}, 2'b00};
            w_count_miss    = 1'b1;
          end
        end
      end
      S_MISS: begin
        if (mem_resp_valid) begin
          w_fill_we = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_last) begin
            w_install       = 1'b1;
            w_req_valid_nxt = 1'b0;
          end else begin
            w_req_addr_nxt = {r_line_hi, w_cnt_inc, 2'b00};
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, valid bits and refill bookkeeping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit           <= 1'b0;
      hit_inst      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      r_valid       <= '0;
      r_line_hi     <= '0;
      r_cnt         <= '0;
    end else if (rdy_in) begin
      hit           <= w_hit_nxt;
      hit_inst      <= w_hit_inst_nxt;
      mem_req_valid <= w_req_valid_nxt;
      mem_req_addr  <= w_req_addr_nxt;
      r_line_hi     <= w_line_hi_nxt;
      r_cnt         <= w_cnt_nxt;
      if (w_install) begin
        r_valid[w_fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_fill_we) begin
      r_data[w_fill_idx][r_cnt] <= mem_resp_data;
    end
    if (rdy_in && w_install) begin
      r_tag[w_fill_idx] <= w_fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
    end else if (rdy_in) begin
      if (w_count_hit) begin
        r_perf_hits <= r_perf_hits + 32'd1;
      end
      if (w_count_miss) begin
        r_perf_misses <= r_perf_misses + 32'd1;
      end
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_count_hit ^ w_count_miss;
  assign perf_hits     = 32'h0;
  assign perf_misses   = 32'h0;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache that answers the instruction-fetch unit's `fetch_valid`/`fetch_pc` requests with a single-cycle `hit`/`hit_inst` pulse. It sits between InsFetch and the memory controller. On a miss it refills a whole line through a word-wide request/response port. It ignores branch flushes except that it never lets them corrupt a line.

## Interface
Parameters:
- `INDEX_BITS`, 6: line-index width (2^6 = 64 lines).
- `OFFSET_BITS`, 2: word-offset width (2^2 = 4 words per line, 16 B).

Ports:
- `clk_in`  in  1  clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rdy_in`  in  1  global enable; low freezes all state.
- `fetch_valid`  in  1  fetch request, held until `hit` is sampled or `rob_clear`.
- `fetch_pc`  in  32  fetch address; bits [1:0] ignored.
- `rob_clear`  in  1  pipeline flush.
- `hit`  out  1  one-cycle response pulse.
- `hit_inst`  out  32  instruction word; valid while `hit`=1.
- `mem_req_valid`  out  1  refill word request.
- `mem_req_addr`  out  32  word-aligned refill address.
- `mem_resp_valid`  in  1  one-cycle pulse, consumes the current request.
- `mem_resp_data`  in  32  refill word, valid with `mem_resp_valid`.
- `perf_hits`  out  32  hit counter (see Configuration).
- `perf_misses`  out  32  miss counter (see Configuration).

## Operation
- Address split: word offset `pc[OFFSET_BITS+1:2]`, index `pc[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2]`, tag = remaining upper bits (defaults: [3:2], [9:4], [31:10]).
- Storage:
  - per line, a valid bit, a tag and 2^OFFSET_BITS data words;
  - only the valid bits are reset;
  - data and tag arrays are not reset.
- FSM states are IDLE, RESP and MISS.
  - IDLE, with `fetch_valid` and `rob_clear`=0:
    - On a tag match with the valid bit set, drive `hit`=1 and `hit_inst` = the addressed word, then go to RESP.
    - Otherwise go to MISS. Latch `line_base` = `{pc[31:OFFSET_BITS+2], 0}` and set the word counter to 0.
  - RESP: drive `hit`=0 and ignore `fetch_valid` for this cycle, then go to IDLE. This stops a still-high `fetch_valid` (the fetch unit drops it one edge late) from causing a duplicate hit.
  - MISS:
    - Drive `mem_req_valid`=1 and `mem_req_addr` = `line_base` + 4×counter.
    - On each `mem_resp_valid`, write the word into the line and increment the counter.
    - After the last word, set valid, write the tag, drop `mem_req_valid` and go to IDLE.
    - The still-pending fetch then hits on the next lookup.
- `rob_clear`:
  - In IDLE it blocks any lookup that cycle: no hit and no miss start.
  - In RESP there is no effect.
  - In MISS the refill continues to completion and the line is installed. Any `fetch_valid` is ignored until the FSM is back in IDLE.
- Replacement: a refill overwrites the indexed line unconditionally.
- `rdy_in`=0: no state change, no counter change, and outputs hold. The memory side is frozen by the same `rdy_in`.

## Timing
- Reset values:
  - `hit`=0, `hit_inst`=0, `mem_req_valid`=0, `mem_req_addr`=0;
  - all valid bits 0, FSM=IDLE;
  - `perf_hits`=0, `perf_misses`=0.
- Reset is asynchronous, so asserting it mid-refill aborts the refill and leaves the line invalid. The memory controller is reset by the same `rst_in`.
- Hit latency: `fetch_valid` sampled at edge N → `hit`=1 during cycle N+1 (registered output) → `hit`=0 during cycle N+2.
- Miss latency:
  - edge N detects the miss;
  - `mem_req_valid` is high from cycle N+1;
  - the Kth response edge completes the refill, where K = 2^OFFSET_BITS (4 by default);
  - the next edge performs the lookup;
  - `hit` is high in the following cycle.
- Memory handshake:
  - `mem_req_addr` is stable while `mem_req_valid`=1 until a response;
  - it advances at that response edge;
  - `mem_req_valid` drops at the final response edge;
  - at most one word is outstanding.

## Configuration
- Macro: `ICACHE_PERF_EN`.
- Defined:
  - `perf_hits` increments on every edge that sets `hit`;
  - `perf_misses` increments on every edge that enters MISS;
  - both wrap modulo 2^32.
- Undefined: the counter registers are not built and both ports are tied to 32'h0.

## Test plan
- Cold miss, `fetch_pc`=0x0000_0000 → requests 0x0, 0x4, 0x8, 0xC, each answered after 2 cycles. Then `hit`=1 for exactly one cycle with `hit_inst` = the word returned for 0x0. `perf_misses`=1.
- After that fill, fetch 0x0000_0008 → `hit` in the cycle after the request with the 0x8 word, no memory request, and `hit` low the next cycle while `fetch_valid` is still high.
- Conflict: fill 0x000, then fetch 0x400 (same index) → refill 0x400–0x40C. A subsequent fetch of 0x000 misses again; `perf_misses`=3.
- `rob_clear` after the 2nd refill response → refill finishes 4 words and `hit` stays 0. A new fetch 0x4 issued during the refill hits after return to IDLE, with no new requests.
- `rst_in` pulse mid-refill, asynchronous between edges → `mem_req_valid`, `hit` and the counters are 0 immediately. Refetching that address misses.
- `rdy_in`=0 for 3 cycles during a refill with `mem_resp_valid` held 0 → `mem_req_addr` and the counter are unchanged, and operation resumes identically afterwards.
